id_issue_ctrl: RTL and testbench
================================

// Module: id_issue_ctrl
// PURPOSE
//  Issue controller for the decode stage. Holds one fetched instruction in the ID slot and tracks
//  in-flight register writes in a per-register scoreboard. Issues to EX with valid/ready only when
//  no RAW hazard exists; stalls IF otherwise. Sits between IF and the decode/EX boundary.
// PARAMETERS
//  CNT_W         2    width of each per-register pending-write counter (max 2**CNT_W-1 in flight per reg)
//  MAX_INFLIGHT  4    cap on total outstanding writes across all registers
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   asynchronous, active-high reset
//  if_valid    in   1   IF presents instruction
//  if_instr    in   32  instruction from IF
//  if_ready    out  1   ID slot can accept this cycle
//  flush       in   1   redirect: discard ID slot contents
//  id_valid    out  1   ID slot holds an issuable instruction (hazard-free)
//  id_instr    out  32  ID slot instruction, registered
//  ex_ready    in   1   EX accepts issue this cycle
//  wb_valid    in   1   writeback retiring a register write
//  wb_rd       in   5   writeback destination
//  hazard      out  1   ID slot occupied but blocked by scoreboard or inflight cap
//  inflight    out  $clog2(MAX_INFLIGHT+1)  total outstanding writes
// BEHAVIOUR
//  - Reset (async): slot empty, id_instr=0, all counters 0, inflight=0; outputs: if_ready=1,
//    id_valid=0, hazard=0.
//  - Slot FSM: EMPTY -> FULL on if_valid&&if_ready; FULL -> EMPTY on issue with no new fetch;
//    FULL -> FULL on issue&&if_valid (back-to-back, zero bubble); any state -> EMPTY on flush.
//  - Register use decoded from id_instr[6:0]: LOAD/OP-IMM/JALR: rs1,rd; STORE/BRANCH: rs1,rs2;
//    OP: rs1,rs2,rd; JAL/LUI/AUIPC: rd; other opcodes: none (issue, untracked).
//    Fields: rs1=[19:15], rs2=[24:20], rd=[11:7]. x0 never hazards, never tracked.
//  - hazard = FULL && (used rs1/rs2 counter != 0, or rd counter saturated, or inflight==MAX_INFLIGHT
//    with rd used). id_valid = FULL && !hazard && !flush. issue = id_valid && ex_ready.
//  - if_ready = EMPTY || issue || flush; combinational, no dependence on if_valid.
//  - On issue with rd used: cnt[rd]++, inflight++. On wb_valid (wb_rd!=0): cnt[wb_rd]--, inflight--.
//    Same register both in one cycle: net unchanged. wb on zero counter: ignored (no underflow).
//  - Flush drops slot only; already-issued writes still retire via wb. Flush and if_valid same
//    cycle: incoming instruction is dropped (slot EMPTY next cycle).
//  - Latency: fetch-to-issue 1 cycle minimum; wb clears hazard for the next cycle (no same-cycle bypass).
//  - id_instr changes only on accepted fetch; stable while FULL and not issued.
// CONFIGURATION
//  ID_PERF_EN defined: adds out port stall_cycles[31:0], reset 0, +1 each cycle hazard=1,
//    wraps 0xFFFFFFFF->0. Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  - rv32i_pkg: opcode localparams (OPC_LOAD, OPC_STORE, OPC_OP, OPC_OPIMM, OPC_BRANCH,
//    OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC), typedef logic [4:0] reg_idx_t, reg-use struct.
//  - Sub-module id_scoreboard: 32 x CNT_W counters + inflight count; ports set_en/set_rd,
//    clr_en/clr_rd, query rs1/rs2/rd -> busy1/busy2/rd_sat. Slot FSM and decode in top.
// TESTING
//  - Reset mid-stream: rst pulse while FULL with cnt[5]=1 -> slot EMPTY, cnt all 0, if_ready=1 same cycle.
//  - Load-use: issue LW x5 (0x0002A283) then ADD x6,x5,x1 -> hazard=1, id_valid=0 until wb_valid wb_rd=5;
//    id_valid=1 the following cycle.
//  - Back-to-back independent: ADDI x1; ADDI x2 with ex_ready=1 -> one issue per cycle, if_ready held 1,
//    inflight reaches 2.
//  - Simultaneous set/clear: issue ADDI x3 while wb_rd=3 with cnt[3]=1 -> cnt[3] stays 1, inflight unchanged.
//  - Inflight cap: 4 unretired writes, slot ADDI x7 -> hazard=1; slot SW (no rd) with ready regs -> issues.
//  - Flush with if_valid=1 while FULL -> slot EMPTY next cycle, id_valid=0, counters unchanged.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Package: rv32i_pkg
// Shared RV32I decode definitions for the decode-stage issue logic:
//   - base opcode constants
//   - reg_idx_t: architectural register index
//   - reg_use_t: which register fields an instruction reads/writes
//   - decode_use(): opcode-driven register-use decode with x0 suppressed
package rv32i_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef logic [4:0] reg_idx_t;

  typedef struct packed {
    logic     use_rs1;
    logic     use_rs2;
    logic     use_rd;
    reg_idx_t rs1;
    reg_idx_t rs2;
    reg_idx_t rd;
  } reg_use_t;

  // x0 is masked out here so downstream logic never hazards on or tracks it.
  function automatic reg_use_t decode_use(input logic [31:0] instr);
    reg_use_t u;
    u.rs1     = instr[19:15];
    u.rs2     = instr[24:20];
    u.rd      = instr[11:7];
    u.use_rs1 = 1'b0;
    u.use_rs2 = 1'b0;
    u.use_rd  = 1'b0;
    case (instr[6:0])
      OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
        u.use_rs1 = 1'b1;
        u.use_rd  = 1'b1;
      end
      OPC_STORE, OPC_BRANCH: begin
        u.use_rs1 = 1'b1;
        u.use_rs2 = 1'b1;
      end
      OPC_OP: begin
        u.use_rs1 = 1'b1;
        u.use_rs2 = 1'b1;
        u.use_rd  = 1'b1;
      end
      OPC_JAL, OPC_LUI, OPC_AUIPC: begin
        u.use_rd = 1'b1;
      end
      default: ;
    endcase
    u.use_rs1 = u.use_rs1 && (u.rs1 != '0);
    u.use_rs2 = u.use_rs2 && (u.rs2 != '0);
    u.use_rd  = u.use_rd && (u.rd != '0);
    return u;
  endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Module: id_scoreboard
// Per-register pending-write scoreboard plus a total in-flight write count.
// Ports:
//   clk, rst           clock, async active-high reset
//   set_en, set_rd     record a new in-flight write to set_rd (x0 ignored)
//   clr_en, clr_rd     retire one write to clr_rd (x0 / zero counter ignored)
//   rs1, rs2, rd       query indices
//   busy1, busy2       rs1 / rs2 have a pending write
//   rd_sat             rd counter is at its maximum
//   inflight           total outstanding writes
module id_scoreboard
  import rv32i_pkg::*;
#(
  parameter int unsigned CNT_W        = 2,
  parameter int unsigned MAX_INFLIGHT = 4,
  localparam int unsigned INF_W       = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  reg_idx_t         set_rd,
  input  logic             clr_en,
  input  reg_idx_t         clr_rd,
  input  reg_idx_t         rs1,
  input  reg_idx_t         rs2,
  input  reg_idx_t         rd,
  output logic             busy1,
  output logic             busy2,
  output logic             rd_sat,
  output logic [INF_W-1:0] inflight
);

  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic [INF_W-1:0] inflight_d;
  logic             set_eff;
  logic             clr_eff;

  always_comb begin
    set_eff    = set_en && (set_rd != '0);
    // A retire against an idle register is dropped so counters cannot underflow.
    clr_eff    = clr_en && (clr_rd != '0) && (cnt_q[clr_rd] != '0);
    cnt_d      = cnt_q;
    inflight_d = inflight;
    if (!(set_eff && clr_eff && (set_rd == clr_rd))) begin
      if (set_eff) cnt_d[set_rd] = cnt_q[set_rd] + CNT_W'(1);
      if (clr_eff) cnt_d[clr_rd] = cnt_q[clr_rd] - CNT_W'(1);
    end
    case ({set_eff, clr_eff})
      2'b10:   inflight_d = inflight + INF_W'(1);
      2'b01:   inflight_d = inflight - INF_W'(1);
      default: inflight_d = inflight;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
      inflight <= '0;
    end else begin
      cnt_q    <= cnt_d;
      inflight <= inflight_d;
    end
  end

  assign busy1  = (cnt_q[rs1] != '0);
  assign busy2  = (cnt_q[rs2] != '0);
  assign rd_sat = (cnt_q[rd] == {CNT_W{1'b1}});

endmodule

// File: rtl/id_issue_ctrl.sv
// Module: id_issue_ctrl
// Decode-stage issue controller: one-entry ID slot fed by IF, issued to EX only when the
// scoreboard shows no RAW hazard and the in-flight write cap has room for its rd.
// Ports:
//   clk, rst                clock, async active-high reset
//   if_valid, if_instr      fetch handshake in;  if_ready out (combinational)
//   flush                   discard ID slot contents (and any same-cycle fetch)
//   id_valid, id_instr      issue handshake out; ex_ready in
//   wb_valid, wb_rd         writeback retiring a register write
//   hazard                  slot occupied but blocked
//   inflight                total outstanding writes
//   stall_cycles            hazard cycle counter (only when ID_PERF_EN is defined)
// Configuration: define ID_PERF_EN to add the stall_cycles performance counter.
module id_issue_ctrl
  import rv32i_pkg::*;
#(
  parameter int unsigned CNT_W        = 2,
  parameter int unsigned MAX_INFLIGHT = 4,
  localparam int unsigned INF_W       = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [31:0]      if_instr,
  output logic             if_ready,
  input  logic             flush,
  output logic             id_valid,
  output logic [31:0]      id_instr,
  input  logic             ex_ready,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  output logic             hazard,
  output logic [INF_W-1:0] inflight
`ifdef ID_PERF_EN
  ,
  output logic [31:0]      stall_cycles
`endif
);

  typedef enum logic {StEmpty, StFull} slot_state_e;

  slot_state_e state_q;
  reg_use_t    use_id;
  logic        full;
  logic        busy1;
  logic        busy2;
  logic        rd_sat;
  logic        cap_hit;
  logic        issue;

  assign full   = (state_q == StFull);
  assign use_id = decode_use(id_instr);

  id_scoreboard #(
    .CNT_W        (CNT_W),
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issue && use_id.use_rd),
    .set_rd   (use_id.rd),
    .clr_en   (wb_valid),
    .clr_rd   (wb_rd),
    .rs1      (use_id.rs1),
    .rs2      (use_id.rs2),
    .rd       (use_id.rd),
    .busy1    (busy1),
    .busy2    (busy2),
    .rd_sat   (rd_sat),
    .inflight (inflight)
  );

  // Cap only blocks instructions that would add another in-flight write.
  assign cap_hit  = (inflight == INF_W'(MAX_INFLIGHT));
  assign hazard   = full && ((use_id.use_rs1 && busy1) || (use_id.use_rs2 && busy2) ||
                             (use_id.use_rd && (rd_sat || cap_hit)));
  assign id_valid = full && !hazard && !flush;
  assign issue    = id_valid && ex_ready;
  assign if_ready = !full || issue || flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StEmpty;
      id_instr <= '0;
    end else if (flush) begin
      // A fetch arriving with flush is on the wrong path; drop it.
      state_q <= StEmpty;
    end else if (if_valid && if_ready) begin
      state_q  <= StFull;
      id_instr <= if_instr;
    end else if (issue) begin
      state_q <= StEmpty;
    end
  end

`ifdef ID_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (hazard) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Testbench: tb_id_issue_ctrl
// Directed scenarios followed by random traffic, every cycle checked against a reference model
// built from per-register pending-write counts and a one-entry slot.
module tb_id_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_instr;
  logic        ex_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        hazard;
  logic [2:0]  inflight;
`ifdef ID_PERF_EN
  logic [31:0] stall_cycles;
`endif

  id_issue_ctrl #(
    .CNT_W        (2),
    .MAX_INFLIGHT (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_valid (if_valid),
    .if_instr (if_instr),
    .if_ready (if_ready),
    .flush    (flush),
    .id_valid (id_valid),
    .id_instr (id_instr),
    .ex_ready (ex_ready),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .hazard   (hazard),
    .inflight (inflight)
`ifdef ID_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit          m_full;
  logic [31:0] m_instr;
  int          m_cnt [32];
  int          m_infl;
  logic [31:0] m_stall;

  localparam logic [31:0] LW_X5   = 32'h0002A283;
  localparam logic [31:0] ADD_651 = 32'h00128333;  // add x6,x5,x1
  localparam logic [31:0] ADDI_X1 = 32'h00000093;
  localparam logic [31:0] ADDI_X2 = 32'h00000113;
  localparam logic [31:0] ADDI_X3 = 32'h00000193;
  localparam logic [31:0] ADDI_X4 = 32'h00000213;
  localparam logic [31:0] ADDI_X5 = 32'h00000293;
  localparam logic [31:0] ADDI_X7 = 32'h00000393;
  localparam logic [31:0] SW_X0   = 32'h00002023;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Source/destination registers straight from the opcode table; -1 means not used.
  function automatic void reg_use(input logic [31:0] ins, output int s1, output int s2,
                                  output int d);
    int r1 = int'(ins[19:15]);
    int r2 = int'(ins[24:20]);
    int rd = int'(ins[11:7]);
    s1 = -1; s2 = -1; d = -1;
    case (ins[6:0])
      7'h03, 7'h13, 7'h67: begin s1 = r1; d = rd; end
      7'h23, 7'h63:        begin s1 = r1; s2 = r2; end
      7'h33:               begin s1 = r1; s2 = r2; d = rd; end
      7'h6F, 7'h37, 7'h17: d = rd;
      default: ;
    endcase
    if (s1 == 0) s1 = -1;
    if (s2 == 0) s2 = -1;
    if (d == 0) d = -1;
  endfunction

  function automatic bit m_hazard();
    int s1, s2, d;
    if (!m_full) return 1'b0;
    reg_use(m_instr, s1, s2, d);
    return (s1 > 0 && m_cnt[s1] > 0) || (s2 > 0 && m_cnt[s2] > 0) ||
           (d > 0 && (m_cnt[d] == 3 || m_infl == 4));
  endfunction

  task automatic model_reset();
    m_full  = 0;
    m_instr = '0;
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_infl  = 0;
    m_stall = '0;
  endtask

  // One clock cycle: drive after negedge, check outputs, then advance model at posedge.
  task automatic step(input logic iv, input logic [31:0] ins, input logic fl, input logic er,
                      input logic wv, input logic [4:0] wr);
    bit hz, idv, iss, ifr, clr;
    int s1, s2, d;
    @(negedge clk);
    if_valid = iv; if_instr = ins; flush = fl; ex_ready = er; wb_valid = wv; wb_rd = wr;
    #1;
    hz  = m_hazard();
    idv = m_full && !hz && !fl;
    iss = idv && er;
    ifr = !m_full || iss || fl;
    check("if_ready", {31'b0, if_ready}, {31'b0, ifr});
    check("id_valid", {31'b0, id_valid}, {31'b0, idv});
    check("hazard", {31'b0, hazard}, {31'b0, hz});
    check("id_instr", id_instr, m_instr);
    check("inflight", {29'b0, inflight}, 32'(m_infl));
`ifdef ID_PERF_EN
    check("stall_cycles", stall_cycles, m_stall);
`endif
    @(posedge clk);
    clr = wv && wr != 0 && m_cnt[wr] > 0;
    reg_use(m_instr, s1, s2, d);
    if (iss && d > 0) begin m_cnt[d]++; m_infl++; end
    if (clr) begin m_cnt[wr]--; m_infl--; end
    if (hz) m_stall = m_stall + 32'd1;
    if (fl) m_full = 0;
    else if (iv && ifr) begin m_full = 1; m_instr = ins; end
    else if (iss) m_full = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_if_ready"}, {31'b0, if_ready}, 32'd1);
    check({tag, "_id_valid"}, {31'b0, id_valid}, 32'd0);
    check({tag, "_hazard"}, {31'b0, hazard}, 32'd0);
    check({tag, "_inflight"}, {29'b0, inflight}, 32'd0);
    check({tag, "_id_instr"}, id_instr, 32'd0);
`ifdef ID_PERF_EN
    check({tag, "_stall"}, stall_cycles, 32'd0);
`endif
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [10];
    logic [31:0] ins;
    ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h33, 7'h6F, 7'h37, 7'h17, 7'h0F};
    ins        = $urandom;
    ins[6:0]   = ops[$urandom_range(0, 9)];
    ins[11:7]  = 5'($urandom_range(0, 5));
    ins[19:15] = 5'($urandom_range(0, 5));
    ins[24:20] = 5'($urandom_range(0, 5));
    return ins;
  endfunction

  initial begin
    rst = 1'b1; if_valid = 0; if_instr = '0; flush = 0; ex_ready = 0; wb_valid = 0; wb_rd = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Load-use: ADD waits on x5 until the cycle after its writeback.
    step(1, LW_X5, 0, 1, 0, 0);
    step(1, ADD_651, 0, 1, 0, 0);
    step(0, '0, 0, 1, 0, 0);
    step(0, '0, 0, 1, 0, 0);
    step(0, '0, 0, 1, 1, 5);
    step(0, '0, 0, 1, 0, 0);
    // Back-to-back independent issue.
    step(1, ADDI_X1, 0, 1, 0, 0);
    step(1, ADDI_X2, 0, 1, 0, 0);
    step(0, '0, 0, 1, 1, 6);
    step(0, '0, 0, 1, 1, 1);
    step(0, '0, 0, 1, 1, 2);
    // Simultaneous set/clear on x3.
    step(1, ADDI_X3, 0, 1, 0, 0);
    step(1, ADDI_X3, 0, 1, 0, 0);
    step(0, '0, 0, 1, 1, 3);
    step(0, '0, 0, 1, 1, 3);
    // Inflight cap, then flush with a concurrent fetch, then a store that issues.
    step(1, ADDI_X1, 0, 1, 0, 0);
    step(1, ADDI_X2, 0, 1, 0, 0);
    step(1, ADDI_X3, 0, 1, 0, 0);
    step(1, ADDI_X4, 0, 1, 0, 0);
    step(1, ADDI_X7, 0, 1, 0, 0);
    step(0, '0, 0, 1, 0, 0);
    step(1, SW_X0, 1, 1, 0, 0);
    step(1, SW_X0, 0, 1, 0, 0);
    step(0, '0, 0, 1, 0, 0);
    for (int r = 1; r <= 4; r++) step(0, '0, 0, 1, 1, 5'(r));
    // Reset mid-stream while FULL with x5 pending.
    step(1, ADDI_X5, 0, 1, 0, 0);
    step(1, ADD_651, 0, 1, 0, 0);
    @(negedge clk);
    if_valid = 0; flush = 0; ex_ready = 0; wb_valid = 0;
    #1 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1, ADD_651, 0, 1, 0, 0);
    step(0, '0, 0, 1, 0, 0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      logic       wv;
      logic [4:0] wr;
      int         pend [$];
      int         s1, s2, d;
      wv = 0; wr = '0;
      if ($urandom_range(0, 99) < 35) begin
        wv = 1;
        pend = {};
        for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) pend.push_back(r);
        if (pend.size() > 0 && $urandom_range(0, 4) != 0)
          wr = 5'(pend[$urandom_range(0, pend.size() - 1)]);
        else
          wr = 5'($urandom_range(0, 5));
        // Avoid retiring an idle register that the slot may be about to set.
        reg_use(m_instr, s1, s2, d);
        if (m_full && m_cnt[wr] == 0 && int'(wr) == d) wr = '0;
      end
      step(1'($urandom_range(0, 99) < 70), rand_instr(), 1'($urandom_range(0, 99) < 4),
           1'($urandom_range(0, 99) < 75), wv, wr);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
